// File: rtl/spi_sram_pkg.sv
// Shared opcodes, slot boundaries and FSM state encoding for the serial-SRAM target.
package spi_sram_pkg;

   localparam logic [7:0] CMD_READ  = 8'h03;
   localparam logic [7:0] CMD_WRITE = 8'h02;
   localparam logic [7:0] CMD_RDSR  = 8'h05;
   localparam logic [7:0] CMD_WRSR  = 8'h01;

   localparam logic [7:0] STATUS_SEQ = 8'h40;
   localparam int unsigned DUMMY_LEN = 8;

   localparam int unsigned CNT_W = 6;
   localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(7);
   localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(31);
   localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'(32 + DUMMY_LEN - 1);

   typedef enum logic [2:0] {
      IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE
   } state_t;

endpackage

// File: rtl/spi_sram_shifter.sv
// Serial datapath: MOSI receive shifter, MISO transmit shifter and the slot counter.
module spi_sram_shifter
   import spi_sram_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic             en2,
   input  logic             mosi,
   input  logic             load,
   input  logic [7:0]       load_data,
   output logic [7:0]       rx_byte,
   output logic [CNT_W-1:0] bit_cnt,
   output logic             miso
);

   logic [6:0] rx_q;
   logic [7:0] tx_q;

   // NOTE: state updates use <= so every flop samples pre-edge values; = here would chain the shifts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_q    <= '0;
         tx_q    <= '0;
         bit_cnt <= '0;
      end else if (clr) begin
         rx_q    <= '0;
         tx_q    <= '0;
         bit_cnt <= '0;
      end else begin
         if (en) begin
            rx_q    <= rx_byte[6:0];
            bit_cnt <= bit_cnt + CNT_W'(1);
         end
         if (en2) begin
            tx_q <= load ? load_data : {tx_q[6:0], 1'b0};
         end
      end
   end

   // Includes the bit currently on mosi so a byte is usable in the cycle its last bit arrives.
   assign rx_byte = {rx_q, mosi};
   assign miso    = tx_q[7];

endmodule

// File: rtl/spi_sram_slv.sv
// 23LC-style SPI SRAM target: opcode/address decode FSM and registered byte memory port.
// Optional SPI_SRAM_RDSR_EN adds RDSR (returns 0x40 repeatedly) and WRSR (byte discarded).
module spi_sram_slv
   import spi_sram_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        en2,
   input  logic        cs_n,
   input  logic        mosi,
   output logic        miso,
   output logic [23:0] mem_addr,
   output logic        mem_en,
   output logic        mem_wr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata
);

   state_t           state, state_nxt;
   logic [7:0]       rx_byte;
   logic [CNT_W-1:0] bit_cnt;
   logic             rd_cmd_q, rdsr_q, rd_pend;
   logic [7:0]       rd_buf, tx_data;
   logic             fetch, wr_strobe, tx_load, rdsr_start, cmd_done;

   spi_sram_shifter u_shifter (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (cs_n),
      .en        (en),
      .en2       (en2),
      .mosi      (mosi),
      .load      (tx_load),
      .load_data (tx_data),
      .rx_byte   (rx_byte),
      .bit_cnt   (bit_cnt),
      .miso      (miso)
   );

   assign cmd_done = !cs_n && state == CMD && en && bit_cnt == CMD_LAST;
   assign tx_data  = (rdsr_q || rdsr_start) ? STATUS_SEQ : rd_buf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (cs_n) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:  state_nxt = CMD;
            CMD: begin
               if (en && bit_cnt == CMD_LAST) begin
                  case (rx_byte)
                     CMD_READ, CMD_WRITE: state_nxt = ADDR;
`ifdef SPI_SRAM_RDSR_EN
                     CMD_RDSR: state_nxt = RDATA;
                     // No status register is modelled, so the WRSR byte is simply swallowed.
                     CMD_WRSR: state_nxt = IGNORE;
`endif
                     default: state_nxt = IGNORE;
                  endcase
               end
            end
            ADDR:  if (en && bit_cnt == ADDR_LAST)  state_nxt = rd_cmd_q ? DUMMY : WDATA;
            DUMMY: if (en && bit_cnt == DUMMY_LAST) state_nxt = RDATA;
            default: state_nxt = state;
         endcase
      end
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      fetch      = 1'b0;
      wr_strobe  = 1'b0;
      tx_load    = 1'b0;
      rdsr_start = 1'b0;
      if (!cs_n) begin
         case (state)
            ADDR:    fetch     = en && bit_cnt == ADDR_LAST && rd_cmd_q;
            RDATA:   fetch     = en && bit_cnt[2:0] == 3'd0 && !rdsr_q;
            WDATA:   wr_strobe = en && bit_cnt[2:0] == 3'd7;
            default: ;
         endcase
`ifdef SPI_SRAM_RDSR_EN
         rdsr_start = cmd_done && rx_byte == CMD_RDSR;
`endif
         tx_load = en2 && bit_cnt[2:0] == 3'd7 &&
                   (state == DUMMY || state == RDATA || rdsr_start);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_cmd_q <= 1'b0;
         rdsr_q   <= 1'b0;
      end else if (cmd_done) begin
         rd_cmd_q <= rx_byte == CMD_READ;
`ifdef SPI_SRAM_RDSR_EN
         rdsr_q   <= rx_byte == CMD_RDSR;
`endif
      end
   end

   // mem_addr doubles as the address shifter; it steps once after every strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_en    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rd_pend   <= 1'b0;
         rd_buf    <= '0;
      end else begin
         mem_en  <= fetch || wr_strobe;
         rd_pend <= mem_en && !mem_wr;
         if (rd_pend)             rd_buf    <= mem_rdata;
         if (fetch || wr_strobe)  mem_wr    <= wr_strobe;
         if (wr_strobe)           mem_wdata <= rx_byte;
         if (!cs_n && state == ADDR && en) mem_addr <= {mem_addr[22:0], mosi};
         else if (mem_en)                  mem_addr <= mem_addr + 24'd1;
      end
   end

endmodule

// File: tb/tb_spi_sram_slv.sv
// Self-checking bench: table of SPI transactions, strobe scoreboard, hand-written reset/abort cases.
module tb_spi_sram_slv;
   import spi_sram_pkg::*;

   logic        clk, rst_n, en, en2, cs_n, mosi, miso;
   logic [23:0] mem_addr;
   logic        mem_en, mem_wr;
   logic [7:0]  mem_wdata, mem_rdata;

   typedef struct {
      logic [7:0]  op;
      logic [23:0] addr;
      int          n;
      logic [7:0]  d0;
      logic [7:0]  d1;
   } vec_t;

   typedef struct {
      logic [23:0] addr;
      logic        wr;
      logic [7:0]  data;
   } acc_t;

   acc_t        exp_q [$];
   acc_t        mon_e;
   logic [7:0]  ref_mem [int unsigned];
   // The model decodes 16 address bits; every address the bench touches is distinct there.
   logic [7:0]  sram [65536] = '{default: 8'h00};
   vec_t        vecs [10];
   int          n_checks = 0;
   int          n_pass = 0;

   spi_sram_slv dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .en2       (en2),
      .cs_n      (cs_n),
      .mosi      (mosi),
      .miso      (miso),
      .mem_addr  (mem_addr),
      .mem_en    (mem_en),
      .mem_wr    (mem_wr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_en && !mem_wr) mem_rdata <= sram[mem_addr[15:0]];
      if (mem_en && mem_wr)  sram[mem_addr[15:0]] <= mem_wdata;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (rst_n && mem_en) begin
         check("strobe_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("acc_addr", mem_addr, mon_e.addr);
            check("acc_wr", mem_wr, mon_e.wr);
            if (mon_e.wr) check("acc_wdata", mem_wdata, mon_e.data);
         end
      end
   end

   function automatic logic [7:0] ref_rd(input logic [23:0] a);
      int unsigned k = a;
      return ref_mem.exists(k) ? ref_mem[k] : 8'h00;
   endfunction

   task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
      rx = '0;
      for (int i = 0; i < nb; i++) begin
         @(negedge clk);
         rx[7-i] = miso;
         cs_n = 1'b0; en = 1'b1; en2 = 1'b1; mosi = tx[7-i];
      end
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      spi_bits(tx, 8, rx);
   endtask

   task automatic cs_release();
      @(negedge clk);
      cs_n = 1'b1; en = 1'b0; en2 = 1'b0; mosi = 1'b0;
      @(negedge clk);
      check("miso_idle_after_cs", miso, 1'b0);
      repeat (3) @(negedge clk);
   endtask

   task automatic run_vec(input vec_t v);
      logic [7:0]  got, exp_b, tx_b;
      logic [23:0] a;
      bit is_rd, is_wr, is_sr;
      is_rd = v.op == CMD_READ;
      is_wr = v.op == CMD_WRITE;
      is_sr = 1'b0;
`ifdef SPI_SRAM_RDSR_EN
      is_sr = v.op == CMD_RDSR;
`endif
      spi_byte(v.op, got);
      check("cmd_miso", got, 8'h00);
      if (is_rd || is_wr) begin
         for (int i = 2; i >= 0; i--) begin
            spi_byte(v.addr[8*i +: 8], got);
            check("addr_miso", got, 8'h00);
         end
      end
      if (is_rd) begin
         for (int j = 0; j <= v.n; j++) exp_q.push_back('{v.addr + 24'(j), 1'b0, 8'h00});
         spi_byte(8'hFF, got);
         check("dummy_miso", got, 8'h00);
      end
      for (int j = 0; j < v.n; j++) begin
         a    = v.addr + 24'(j);
         tx_b = (j == 0) ? v.d0 : v.d1;
         if (is_wr) begin
            exp_q.push_back('{a, 1'b1, tx_b});
            ref_mem[a] = tx_b;
         end
         exp_b = is_rd ? ref_rd(a) : (is_sr ? STATUS_SEQ : 8'h00);
         spi_byte(is_wr ? tx_b : 8'h00, got);
         check("data_miso", got, exp_b);
      end
      cs_release();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] dump;
      vecs[0] = '{CMD_WRITE, 24'h000200, 2, 8'hA5, 8'h5A};
      vecs[1] = '{CMD_WRITE, 24'h00FFFC, 2, 8'h00, 8'h04};
      vecs[2] = '{CMD_READ,  24'h00FFFC, 2, 8'h00, 8'h00};
      vecs[3] = '{CMD_WRITE, 24'hFFFFFF, 2, 8'h11, 8'h22};
      vecs[4] = '{CMD_READ,  24'hFFFFFF, 2, 8'h00, 8'h00};
      vecs[5] = '{CMD_READ,  24'h000200, 2, 8'h00, 8'h00};
      vecs[6] = '{8'h9F,     24'h000000, 2, 8'h00, 8'h00};
      vecs[7] = '{CMD_RDSR,  24'h000000, 2, 8'h00, 8'h00};
      vecs[8] = '{CMD_WRSR,  24'h000000, 1, 8'hC3, 8'h00};
      vecs[9] = '{CMD_READ,  24'h000000, 1, 8'h00, 8'h00};

      rst_n = 1'b0; cs_n = 1'b1; en = 1'b0; en2 = 1'b0; mosi = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_miso", miso, 1'b0);
      check("rst_mem_en", mem_en, 1'b0);
      check("rst_mem_wr", mem_wr, 1'b0);
      check("rst_mem_addr", mem_addr, 24'h0);
      check("rst_mem_wdata", mem_wdata, 8'h00);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset asserted halfway through an address: 4 address bits 1010 already shifted.
      spi_byte(CMD_WRITE, dump);
      spi_bits(8'hAB, 4, dump);
      @(negedge clk);
      en = 1'b0; en2 = 1'b0;
      check("pre_rst_addr", mem_addr, 24'h00000A);
      rst_n = 1'b0;
      #1;
      check("mid_rst_addr", mem_addr, 24'h0);
      check("mid_rst_miso", miso, 1'b0);
      check("mid_rst_mem_en", mem_en, 1'b0);
      check("mid_rst_state", dut.state, IDLE);
      cs_n = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_vec('{CMD_READ, 24'h000000, 1, 8'h00, 8'h00});

      for (int i = 0; i < 10; i++) run_vec(vecs[i]);

      // Abort after 5 data bits of a write: no strobe, nothing stored.
      spi_byte(CMD_WRITE, dump);
      spi_byte(8'h00, dump);
      spi_byte(8'h03, dump);
      spi_byte(8'h00, dump);
      spi_bits(8'hFF, 5, dump);
      cs_release();
      run_vec('{CMD_READ, 24'h000300, 1, 8'h00, 8'h00});
      run_vec('{CMD_READ, 24'h000201, 1, 8'h00, 8'h00});

      repeat (5) @(negedge clk);
      check("sb_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/spi_sram_slv.md
# spi_sram_slv

Serial-SRAM target emulator: decodes a 23LC-style SPI byte protocol (opcode, 24-bit address, data) arriving on `mosi`/`cs_n` and converts it into single-byte accesses on a synchronous memory port. It sits between an SPI host and a behavioural or on-chip byte RAM. SCK is not a separate port: one serial bit is transferred per enabled cycle of the system clock.

## Interface

Parameters: none.

Ports (`name direction width meaning`):
- `clk` in 1 — system clock and SPI bit clock; one clock domain, everything on rising edge.
- `rst_n` in 1 — reset, asynchronous assert, active-low.
- `en` in 1 — sample enable; `mosi` is shifted in only on `en` cycles.
- `en2` in 1 — drive enable; `miso` advances only on `en2` cycles.
- `cs_n` in 1 — chip select, active-low; a high level ends the transaction.
- `mosi` in 1 — serial data in, MSB first.
- `miso` out 1 — serial data out, MSB first; 0 when idle.
- `mem_addr` out 24 — byte address.
- `mem_en` out 1 — one-cycle access strobe.
- `mem_wr` out 1 — write qualifier, valid with `mem_en`.
- `mem_wdata` out 8 — write byte.
- `mem_rdata` in 8 — read byte; valid one cycle after `mem_en` with `mem_wr`=0.

## Operation

States: `IDLE`, `CMD`, `ADDR`, `DUMMY`, `RDATA`, `WDATA`, `IGNORE`.

Opcodes:
- `0x03` READ.
- `0x02` WRITE.
- Any other opcode moves to `IGNORE`: `miso`=0, no memory access until `cs_n` rises.

Bit slots are counted from 0 after `cs_n` falls:
- Slots 0–7: opcode.
- Slots 8–31: address, MSB first.

READ:
- Slots 32–39 are dummy slots; `mosi` is ignored.
- Data bytes are output from slot 40 onward.
- Each byte is fetched from the current address, and the address then increments.
- The next byte is fetched while the current byte is shifting out.
- Reading continues until `cs_n` goes high.

WRITE:
- Data bytes start at slot 32.
- After each 8th data bit, one `mem_en`=1, `mem_wr`=1 pulse is issued with the assembled byte, then the address increments.

General rules:
- Address arithmetic is 24-bit and wraps from `0xFFFFFF` to 0.
- `cs_n` high at any point returns the block to `IDLE` and clears the bit counter.
- A partially received write byte is discarded.
- An in-flight read is allowed to complete on the memory port, but its result is ignored.

## Timing

- Reset values: `miso`=0, `mem_en`=0, `mem_wr`=0, `mem_addr`=0, `mem_wdata`=0, state `IDLE`.
- `mem_*` outputs are registered.
- A strobe appears in the cycle after the `en` cycle that completed the triggering bit (address bit 31 for the first read; last data bit for a write).
- `mem_en` is high for exactly one cycle per access.
- The read byte is captured from `mem_rdata` one cycle after `mem_en`.
- `miso` for slot k becomes valid after the `en2` edge that ends slot k−1.
- With `en`=`en2`=1 every cycle, the first data MSB is on `miso` when the host samples slot 40.
- When `cs_n` rises, `miso` returns to 0 on the next cycle.
- A transaction start and end in the same cycle is not possible: `cs_n` is level-sampled each cycle.

## Configuration

Macro `SPI_SRAM_RDSR_EN`:
- Defined: the block also decodes `0x05` RDSR, which returns constant `0x40` (sequential mode) repeatedly while `cs_n` stays low, and `0x01` WRSR, which accepts and discards one byte.
- Undefined: both opcodes fall into `IGNORE`.

## Structure

- Package `spi_sram_pkg` holds the opcode constants (`CMD_READ`, `CMD_WRITE`, `CMD_RDSR`, `CMD_WRSR`), the state enum, and the dummy-byte length constant (8).
- One sub-module, `spi_sram_shifter`, contains the input and output 8-bit shift registers and the bit counter. The top level contains the FSM and the memory-port logic.

## Test plan

1. Reset: `rst_n`=0 mid-transaction → all outputs 0, state `IDLE`. After release, an `0x03` READ from address 0 works.
2. WRITE `02 00 02 00` + bytes `A5 5A` → two write strobes: `0x000200`←`A5`, then `0x000201`←`5A`.
3. READ `03 00 FF FC` + 8 dummy slots, memory[`FFFC`]=`00`, [`FFFD`]=`04` → `miso` carries `00` then `04`. Exactly one `mem_en` per byte; addresses increment.
4. Wrap: WRITE at `FFFFFF` with two bytes → second byte written to address `000000`.
5. Abort: `cs_n` raised after 5 data bits of a WRITE → no strobe. The next transaction decodes normally.
6. Unknown opcode `0x9F` → no `mem_en` and `miso`=0 until `cs_n` rises. With `SPI_SRAM_RDSR_EN` defined, `0x05` returns `0x40`.
